// File: rtl/mdu_iterative.sv
// mdu_iterative: multi-cycle MULT/MULTU/DIV/DIVU unit with private HI/LO and start/busy/done handshake
module mdu_iterative #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rs_data_i,
    input  logic [WIDTH-1:0] rt_data_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state;
    logic             is_div;
    logic             sign_q;
    logic             sign_r;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mplr;

    logic             signed_in;
    logic             accept;
    logic             div_zero;
    logic [WIDTH-1:0] rs_abs;
    logic [WIDTH-1:0] rt_abs;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mplr_next;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    // Operand conditioning, one shift-add / restoring-divide step, and final sign fix-up.
    // acc/mplr double as rem/quot during divide; mcand holds the multiplicand or divisor.
    always_comb begin
        signed_in = ~op_i[0];
        accept    = start_i && !flush_i && (state == IDLE || state == DONE);
        div_zero  = op_i[1] && (rt_data_i == '0);
        rs_abs    = (signed_in && rs_data_i[WIDTH-1]) ? -rs_data_i : rs_data_i;
        rt_abs    = (signed_in && rt_data_i[WIDTH-1]) ? -rt_data_i : rt_data_i;
        mul_sum   = {1'b0, acc} + (mplr[0] ? {1'b0, mcand} : '0);
        div_shift = {acc, mplr[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mcand};
        acc_next  = is_div ? (div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0])
                           : mul_sum[WIDTH:1];
        mplr_next = is_div ? {mplr[WIDTH-2:0], ~div_diff[WIDTH]}
                           : {mul_sum[0], mplr[WIDTH-1:1]};
        prod_s    = sign_q ? -{acc, mplr} : {acc, mplr};
        fix_hi    = is_div ? (sign_r ? -acc : acc) : prod_s[2*WIDTH-1:WIDTH];
        fix_lo    = is_div ? (sign_q ? -mplr : mplr) : prod_s[WIDTH-1:0];
    end

    // Control FSM with registered busy/done and HI/LO result registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= IDLE;
            is_div <= 1'b0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            acc    <= '0;
            mplr   <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            hi_o   <= '0;
            lo_o   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_o <= 1'b0;
                    state  <= IDLE;
                    if (accept) begin
                        is_div <= op_i[1];
                        sign_q <= signed_in && (rs_data_i[WIDTH-1] ^ rt_data_i[WIDTH-1]);
                        sign_r <= signed_in && rs_data_i[WIDTH-1];
                        mcand  <= rt_abs;
                        acc    <= '0;
                        mplr   <= rs_abs;
                        cnt    <= '0;
                        if (div_zero) begin
                            hi_o   <= rs_data_i;
                            lo_o   <= '1;
                            done_o <= 1'b1;
                            state  <= DONE;
                        end else begin
                            busy_o <= 1'b1;
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush_i) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        acc  <= acc_next;
                        mplr <= mplr_next;
                        cnt  <= cnt + 1'b1;
                        if (&cnt) state <= FIX;
                    end
                end
                FIX: begin
                    busy_o <= 1'b0;
                    if (flush_i) begin
                        state <= IDLE;
                    end else begin
                        hi_o   <= fix_hi;
                        lo_o   <= fix_lo;
                        done_o <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: scoreboard bench for mdu_iterative with directed hand-computed vectors
module tb_mdu_iterative;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    mdu_iterative #(.WIDTH(32), .CNT_W(5)) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .start_i(start),
        .op_i(op),
        .rs_data_i(rs),
        .rt_data_i(rt),
        .flush_i(flush),
        .busy_o(busy),
        .done_o(done),
        .hi_o(hi),
        .lo_o(lo)
    );

    always #5 clk = ~clk;

    // Monitor: every done pulse must match the oldest expected result
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done got hi=%h lo=%h, expected no result", hi, lo);
                end else begin
                    e = sb.pop_front();
                    if (hi !== e.hi || lo !== e.lo) begin
                        failures++;
                        $display("FAIL %s got hi=%h lo=%h, expected hi=%h lo=%h", e.name, hi, lo, e.hi, e.lo);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit expect_result, input string name,
                         input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        start = 1'b1;
        op = o;
        rs = a;
        rt = b;
        if (expect_result) begin
            e.name = name;
            e.hi = eh;
            e.lo = el;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int lat, output int bc);
        bit seen = 1'b0;
        lat = 0;
        bc = 0;
        for (int i = 1; i <= 100 && !seen; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) begin
                seen = 1'b1;
                lat = i;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout got no done within 100 cycles, expected done", name);
        end
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input string name, input logic [31:0] eh, input logic [31:0] el,
                       input int exp_lat, input int exp_busy);
        int lat, bc;
        issue(o, a, b, 1'b1, name, eh, el);
        wait_done(name, lat, bc);
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_busy_cycles"}, 64'(bc), 64'(exp_busy));
        @(negedge clk);
    endtask

    initial begin
        int lat, bc;
        repeat (2) @(negedge clk);
        check("reset_outputs", {30'd0, busy, done, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max", 32'hFFFFFFFE, 32'h00000001, 34, 33);
        run(MULT, 32'hFFFFFFFD, 32'd7, "mult_neg3x7", 32'hFFFFFFFF, 32'hFFFFFFEB, 34, 33);
        run(MULT, 32'h80000000, 32'h80000000, "mult_minxmin", 32'h40000000, 32'h00000000, 34, 33);
        run(DIV, 32'hFFFFFFF9, 32'd2, "div_neg7by2", 32'hFFFFFFFF, 32'hFFFFFFFD, 34, 33);
        run(DIV, 32'd7, 32'hFFFFFFFE, "div_7byneg2", 32'h00000001, 32'hFFFFFFFD, 34, 33);
        run(DIVU, 32'd100, 32'd7, "divu_100by7", 32'd2, 32'd14, 34, 33);
        run(DIVU, 32'h12345678, 32'd0, "divu_zero", 32'h12345678, 32'hFFFFFFFF, 1, 0);
        run(DIV, 32'hFFFFFFFB, 32'd0, "div_zero_neg", 32'hFFFFFFFB, 32'hFFFFFFFF, 1, 0);
        run(DIV, 32'h80000000, 32'hFFFFFFFF, "div_overflow", 32'h00000000, 32'h80000000, 34, 33);

        issue(MULTU, 32'd5, 32'd6, 1'b1, "multu_5x6", 32'd0, 32'd30);
        repeat (5) @(negedge clk);
        start = 1'b1;
        op = DIV;
        rs = 32'd1;
        rt = 32'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done("multu_5x6", lat, bc);
        check("start_ignored_latency", 64'(lat + 6), 64'd34);
        @(negedge clk);

        issue(MULTU, 32'd9, 32'd9, 1'b0, "", '0, '0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {63'd0, busy}, 64'd0);
        check("flush_hilo", {hi, lo}, {32'd0, 32'd30});
        repeat (40) @(negedge clk);
        flush = 1'b1;
        start = 1'b1;
        op = MULTU;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        check("flush_over_start", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);

        issue(MULT, 32'hFFFFFFFD, 32'd7, 1'b1, "b2b_first", 32'hFFFFFFFF, 32'hFFFFFFEB);
        wait_done("b2b_first", lat, bc);
        issue(DIVU, 32'd100, 32'd7, 1'b1, "b2b_second", 32'd2, 32'd14);
        @(negedge clk);
        check("b2b_busy", {63'd0, busy}, 64'd1);
        wait_done("b2b_second", lat, bc);
        check("b2b_latency", 64'(lat + 1), 64'd34);
        @(negedge clk);

        issue(MULTU, 32'd3, 32'd3, 1'b0, "", '0, '0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_ctrl", {62'd0, busy, done}, 64'd0);
        check("async_reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        run(MULTU, 32'd12345, 32'd1000, "post_reset", 32'd0, 32'd12345000, 34, 33);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
